// File: rtl/instruction_encoder.sv
// ----------------------------------------------------------------------------
// instruction_encoder
//
// Packs RISC-V instruction fields (R/I/S/B/U/J formats) into 32-bit words and
// queues them in a 2-entry FIFO. Each enqueued word carries an address tag that
// starts at BASE_ADDR after reset and advances by 4 for every enqueued word,
// wrapping modulo 2^32. A bundle that cannot be encoded is still accepted by
// the handshake, but nothing is queued and err_o pulses on the next cycle.
//
// Optional feature macro: INSTRUCTION_ENCODER_CHECK_EN
//   When defined, immediates that do not fit the selected format are rejected
//   in the same way as an unknown format. When undefined, immediates are
//   silently truncated to the bits the format carries.
//
// Ports
//   clk_i          in   clock, all state updates on the rising edge
//   rst_i          in   synchronous active-high reset
//   valid_i        in   field bundle valid
//   ready_o        out  encoder can accept a bundle (registered state only)
//   inst_type_i    in   instruction format selector
//   opcode_i       in   7-bit opcode
//   funct3_i       in   3-bit funct3
//   funct7_i       in   7-bit funct7
//   rd_i           in   5-bit destination register
//   rs1_i          in   5-bit source register 1
//   rs2_i          in   5-bit source register 2
//   imm_i          in   32-bit immediate
//   valid_o        out  output word valid
//   ready_i        in   consumer accepts the output word
//   instruction_o  out  encoded word at the FIFO head
//   addr_o         out  address tag of the FIFO head
//   err_o          out  one-cycle pulse marking a rejected bundle
// ----------------------------------------------------------------------------
package riscv_pkg;
   typedef enum logic [2:0] {
      R_TYPE,
      I_TYPE,
      S_TYPE,
      B_TYPE,
      U_TYPE,
      J_TYPE,
      UNKNOWN_TYPE
   } instruction_type_e;
endpackage

module instruction_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  riscv_pkg::instruction_type_e  inst_type_i,
   input  logic [6:0]                    opcode_i,
   input  logic [2:0]                    funct3_i,
   input  logic [6:0]                    funct7_i,
   input  logic [4:0]                    rd_i,
   input  logic [4:0]                    rs1_i,
   input  logic [4:0]                    rs2_i,
   input  logic [31:0]                   imm_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [31:0]                   instruction_o,
   output logic [31:0]                   addr_o,
   output logic                          err_o
);

   logic [31:0] word_mem [2];
   logic [31:0] addr_mem [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic [31:0] addr_cnt;
   logic        err_q;

   logic [31:0] encoded;
   logic        bad_bundle;
   logic        accept;
   logic        push;
   logic        pop;

   // Format encoder. Unknown formats (and, with the check enabled, immediates
   // that the format cannot represent) flag the bundle as bad.
   always_comb begin
      encoded    = '0;
      bad_bundle = 1'b0;
      unique case (inst_type_i)
         riscv_pkg::R_TYPE: begin
            encoded = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         end
         riscv_pkg::I_TYPE: begin
            encoded = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
`ifdef INSTRUCTION_ENCODER_CHECK_EN
            bad_bundle = (imm_i[31:11] != {21{imm_i[11]}});
`endif
         end
         riscv_pkg::S_TYPE: begin
            encoded = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
`ifdef INSTRUCTION_ENCODER_CHECK_EN
            bad_bundle = (imm_i[31:11] != {21{imm_i[11]}});
`endif
         end
         riscv_pkg::B_TYPE: begin
            encoded = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
`ifdef INSTRUCTION_ENCODER_CHECK_EN
            bad_bundle = (imm_i[31:12] != {20{imm_i[12]}}) || imm_i[0];
`endif
         end
         riscv_pkg::U_TYPE: begin
            encoded = {imm_i[31:12], rd_i, opcode_i};
`ifdef INSTRUCTION_ENCODER_CHECK_EN
            bad_bundle = (imm_i[11:0] != 12'h000);
`endif
         end
         riscv_pkg::J_TYPE: begin
            encoded = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                       rd_i, opcode_i};
`ifdef INSTRUCTION_ENCODER_CHECK_EN
            bad_bundle = (imm_i[31:20] != {12{imm_i[20]}}) || imm_i[0];
`endif
         end
         default: begin
            bad_bundle = 1'b1;
         end
      endcase
   end

   // Handshake decode. ready_o comes from the registered count only, so a
   // full FIFO refuses a push even when the head is popped in the same cycle.
   always_comb begin
      ready_o = (count < 2'd2);
      valid_o = (count != 2'd0);
      accept  = valid_i && ready_o;
      push    = accept && !bad_bundle;
      pop     = valid_o && ready_i;
   end

   // FIFO, address counter and error pulse. Reset wins over any handshake in
   // the same cycle; the storage arrays need no reset because the count gates
   // every read of them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count    <= 2'd0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         addr_cnt <= BASE_ADDR;
         err_q    <= 1'b0;
      end else begin
         if (push) begin
            word_mem[wr_ptr] <= encoded;
            addr_mem[wr_ptr] <= addr_cnt;
            wr_ptr           <= ~wr_ptr;
            addr_cnt         <= addr_cnt + 32'd4;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
         err_q <= accept && bad_bundle;
      end
   end

   // Output view of the FIFO head. When empty the word reads as zero and the
   // address shows the tag the next enqueued word will receive.
   always_comb begin
      instruction_o = valid_o ? word_mem[rd_ptr] : 32'h0000_0000;
      addr_o        = valid_o ? addr_mem[rd_ptr] : addr_cnt;
      err_o         = err_q;
   end

endmodule
